sum_share_arb: RTL and testbench
================================

Name: sum_share_arb

Overview:
- Round-robin arbiter that shares one D_WIDTH adder between two requesters.
- Each requester offers an operand pair (a, b) with a valid/ready handshake.
- At most one pair is granted per cycle. Its sum, tagged with the requester ID, is written into an internal result FIFO, which downstream drains with pop.
- Sits between the operand producers and the down_data consumer in the adder datapath.

Parameters:
- D_WIDTH, 6: width of operands and sum.
- DEPTH, 4: result FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a pair.
- req0_a  in  D_WIDTH  requester 0 operand a.
- req0_b  in  D_WIDTH  requester 0 operand b.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req1_valid  in  1  requester 1 has a pair.
- req1_a  in  D_WIDTH  requester 1 operand a.
- req1_b  in  D_WIDTH  requester 1 operand b.
- req1_ready  out  1  requester 1 pair accepted this cycle.
- down_data  out  D_WIDTH  sum at FIFO head.
- down_id  out  1  requester ID of the head entry.
- down_valid  out  1  FIFO not empty.
- pop  in  1  consume the head entry.
- qsize  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (rst=0, async): the FIFO is emptied (rd_ptr=wr_ptr=0, qsize=0), down_valid=0, down_data=0, down_id=0, last_grant=1 so requester 0 wins first.
- When rst deasserts, the block operates from the next rising edge.
- Reset mid-operation discards every pending entry. No partial writes are allowed.
- Accept condition: acc = (qsize < DEPTH). A pop in the same cycle does NOT free a slot for a push; there is no pass-through.
- Grant, combinational from the valids, last_grant and acc:
  - acc=0: both readys are 0.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = grantN. Any ready is 1 only if acc=1. At most one ready is high per cycle.
- Transfer: reqN_valid & reqN_ready at a rising edge.
  - The edge writes {N, reqN_a + reqN_b} at wr_ptr and increments wr_ptr modulo DEPTH.
  - last_grant <= N.
- last_grant is unchanged on cycles with no transfer.
- Sum: D_WIDTH-bit modulo-2^D_WIDTH add. The carry is dropped unless SUM_SAT_EN is defined.
- Latency: a pair transferred at edge k is visible on down_data/down_id/down_valid after edge k if the FIFO was empty. Head outputs are first-word-fall-through from the storage array.
- Pop: with pop=1 and down_valid=1, rd_ptr increments at the edge. A pop while empty is ignored, with no underflow and qsize held at 0.
- Simultaneous push and pop (FIFO not full): qsize is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full is qsize==DEPTH, empty is qsize==0.
- down_data/down_id read 0 when empty. Head storage contents are don't-care, but the outputs are masked.
- Valid/ready protocol:
  - The requester must hold reqN_a/b stable while valid and not ready.
  - A requester may deassert valid without a transfer; the arbiter keeps no memory of it.
- Fairness: with both requesters continuously valid and no backpressure, grants strictly alternate 0,1,0,1,...
- During backpressure (full), last_grant is frozen. After pop frees a slot, the requester != last_grant is granted first.

Optional Feature:
- Macro: SUM_SAT_EN.
- Defined: the sum saturates to 2^D_WIDTH-1 when the true sum exceeds it.
- Not defined: the sum wraps modulo 2^D_WIDTH, so 63+1=0 at D_WIDTH=6.
- Arbitration, FIFO and latency are identical in both builds.

Test Plan:
- Reset and empty pop: rst low mid-stream, then pop=1 with no requests -> qsize=0, down_valid=0, down_data=0, no underflow.
- Single requester latency: req0 a=5 b=7 for one cycle -> req0_ready=1. Next cycle down_data=12, down_id=0, qsize=1. Pop -> qsize=0.
- Contention: both valid continuously (req0 3+4, req1 10+20), pop=0, DEPTH=4 -> entries 7/id0, 30/id1, 7/id0, 30/id1. After the 4th, readys are 0 and qsize=4.
- Backpressure release: from the full state in the previous scenario, one pop -> next grant goes to requester 0. On the following edge qsize returns to 4 and down_data=30, down_id=1.
- Wrap/saturate: req1 a=63 b=1 -> down_data=0 without SUM_SAT_EN, 63 with it. Also a=32 b=31 -> 63 in both builds.
- Push+pop same cycle at qsize=2: qsize stays 2, the head advances, and pointers wrap correctly over 10 consecutive transfers.

Source files
------------

// File: rtl/sum_share_arb.sv
// sum_share_arb: round-robin arbiter sharing one adder between two requesters, sums queued in a FWFT result FIFO.
// Define SUM_SAT_EN to saturate sums at 2^D_WIDTH-1 instead of wrapping.
module sum_share_arb #(
  parameter int D_WIDTH = 6,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [D_WIDTH-1:0]         req0_a,
  input  logic [D_WIDTH-1:0]         req0_b,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [D_WIDTH-1:0]         req1_a,
  input  logic [D_WIDTH-1:0]         req1_b,
  output logic                       req1_ready,
  output logic [D_WIDTH-1:0]         down_data,
  output logic                       down_id,
  output logic                       down_valid,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     qsize
);
  localparam int AW = $clog2(DEPTH);
  localparam int QW = AW + 1;
  localparam logic [QW-1:0] FULL = QW'(DEPTH);
  logic [D_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]   r_id;
  logic [AW-1:0]      r_wr, r_rd;
  logic [QW-1:0]      r_cnt;
  logic               r_last;
  logic               w_acc, w_g0, w_g1, w_push, w_pop, w_empty;
  logic [D_WIDTH-1:0] w_a, w_b, w_sum;
  assign w_acc  = r_cnt < FULL;
  // ties go to the requester that did not win the last transfer
  assign w_g0   = w_acc & req0_valid & (~req1_valid | r_last);
  assign w_g1   = w_acc & req1_valid & (~req0_valid | ~r_last);
  assign w_push = w_g0 | w_g1;
  assign w_empty = r_cnt == '0;
  assign w_pop  = pop & ~w_empty;
  assign w_a    = w_g1 ? req1_a : req0_a;
  assign w_b    = w_g1 ? req1_b : req0_b;
`ifdef SUM_SAT_EN
  logic [D_WIDTH:0] w_raw;
  assign w_raw = {1'b0, w_a} + {1'b0, w_b};
  assign w_sum = w_raw[D_WIDTH] ? '1 : w_raw[D_WIDTH-1:0];
`else
  assign w_sum = w_a + w_b;
`endif
  assign req0_ready = w_g0;
  assign req1_ready = w_g1;
  assign down_valid = ~w_empty;
  assign down_data  = w_empty ? '0 : r_data[r_rd];
  assign down_id    = w_empty ? 1'b0 : r_id[r_rd];
  assign qsize      = r_cnt;
  always_ff @(posedge clk) begin
    if (w_push && rst) begin
      r_data[r_wr] <= w_sum;
      r_id[r_wr]   <= w_g1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr   <= r_wr + AW'(1);
        r_last <= w_g1;
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + QW'(w_push) - QW'(w_pop);
    end
  end
endmodule

// File: tb/tb_sum_share_arb.sv
// tb_sum_share_arb: directed self-checking bench for sum_share_arb (D_WIDTH=6, DEPTH=4).
module tb_sum_share_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [5:0] req0_a, req0_b, req1_a, req1_b, down_data;
  logic       down_id, down_valid, pop;
  logic [2:0] qsize;
  int checks = 0;
  int errors = 0;
`ifdef SUM_SAT_EN
  localparam int WRAP_EXP = 63;
`else
  localparam int WRAP_EXP = 0;
`endif

  sum_share_arb #(.D_WIDTH(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .down_data(down_data), .down_id(down_id), .down_valid(down_valid),
    .pop(pop), .qsize(qsize)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input int d, input int id, input int q);
    chk({tag, "_data"}, int'(down_data), d);
    chk({tag, "_id"}, int'(down_id), id);
    chk({tag, "_valid"}, int'(down_valid), 1);
    chk({tag, "_qsize"}, int'(qsize), q);
  endtask

  initial begin
    rst = 1'b0; pop = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    #1;
    chk("rst_qsize", int'(qsize), 0);
    chk("rst_valid", int'(down_valid), 0);
    chk("rst_data", int'(down_data), 0);
    chk("rst_id", int'(down_id), 0);
    tick;
    rst = 1'b1;
    tick;
    // push two entries, then reset asynchronously mid-cycle
    req0_valid = 1'b1; req0_a = 6'd9; req0_b = 6'd1;
    tick; tick;
    req0_valid = 1'b0;
    chk("pre_rst_qsize", int'(qsize), 2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_qsize", int'(qsize), 0);
    chk("async_rst_valid", int'(down_valid), 0);
    tick;
    rst = 1'b1;
    pop = 1'b1;
    tick; tick;
    pop = 1'b0;
    chk("empty_pop_qsize", int'(qsize), 0);
    chk("empty_pop_valid", int'(down_valid), 0);
    chk("empty_pop_data", int'(down_data), 0);
    // single requester latency
    req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd7;
    #1;
    chk("single_ready0", int'(req0_ready), 1);
    chk("single_ready1", int'(req1_ready), 0);
    tick;
    req0_valid = 1'b0;
    head("single", 12, 0, 1);
    pop = 1'b1;
    tick;
    pop = 1'b0;
    chk("single_pop_qsize", int'(qsize), 0);
    chk("single_pop_valid", int'(down_valid), 0);
    // contention from a fresh reset so requester 0 wins first
    rst = 1'b0; #2 rst = 1'b1;
    tick;
    req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd4;
    req1_valid = 1'b1; req1_a = 6'd10; req1_b = 6'd20;
    #1;
    chk("cont1_ready0", int'(req0_ready), 1);
    chk("cont1_ready1", int'(req1_ready), 0);
    tick;
    chk("cont2_ready0", int'(req0_ready), 0);
    chk("cont2_ready1", int'(req1_ready), 1);
    tick;
    chk("cont3_ready0", int'(req0_ready), 1);
    chk("cont3_ready1", int'(req1_ready), 0);
    tick;
    chk("cont4_ready0", int'(req0_ready), 0);
    chk("cont4_ready1", int'(req1_ready), 1);
    tick;
    chk("full_ready0", int'(req0_ready), 0);
    chk("full_ready1", int'(req1_ready), 0);
    head("full", 7, 0, 4);
    // backpressure release: pop frees a slot, requester 0 goes first
    pop = 1'b1;
    tick;
    pop = 1'b0;
    head("after_pop", 30, 1, 3);
    chk("release_ready0", int'(req0_ready), 1);
    chk("release_ready1", int'(req1_ready), 0);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    head("refill", 30, 1, 4);
    pop = 1'b1;
    tick;
    head("drain1", 7, 0, 3);
    tick;
    head("drain2", 30, 1, 2);
    tick;
    head("drain3", 7, 0, 1);
    tick;
    pop = 1'b0;
    chk("drain_qsize", int'(qsize), 0);
    chk("drain_valid", int'(down_valid), 0);
    // wrap / saturate boundary
    req1_valid = 1'b1; req1_a = 6'd63; req1_b = 6'd1;
    #1;
    chk("wrap_ready1", int'(req1_ready), 1);
    tick;
    req1_a = 6'd32; req1_b = 6'd31;
    head("wrap", WRAP_EXP, 1, 1);
    pop = 1'b1;
    tick;
    req1_valid = 1'b0;
    head("max", 63, 1, 1);
    tick;
    pop = 1'b0;
    chk("max_pop_qsize", int'(qsize), 0);
    // fill to 2, then 10 simultaneous push+pop cycles
    req0_valid = 1'b1; req0_b = 6'd0;
    req0_a = 6'd1;
    tick;
    req0_a = 6'd2;
    tick;
    chk("pp_start_qsize", int'(qsize), 2);
    pop = 1'b1;
    for (int j = 0; j < 10; j++) begin
      req0_a = 6'(j + 3);
      tick;
      head($sformatf("pp%0d", j), j + 2, 0, 2);
    end
    req0_valid = 1'b0;
    tick;
    head("pp_tail", 12, 0, 1);
    tick;
    pop = 1'b0;
    chk("pp_end_qsize", int'(qsize), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
